// File: rtl/decode_stage_hzd_if.sv
// Decode-stage bundle: IF/ID inputs, WB write port, EX/MEM hazard and
// forwarding information, and the stall/flush/branch and ID/EX outputs.
interface decode_stage_hzd_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_W     = 9
);
  logic                  i_valid;
  logic [31:0]           i_instruccion;
  logic [DATA_WIDTH-1:0] i_currentpc;
  logic [CTRL_W-1:0]     i_ctrl;
  logic                  i_isbranch;
  logic                  i_beq_or_bne;
  logic                  i_zeroext;
  logic                  i_regwrite;
  logic [4:0]            i_rt_rd;
  logic [DATA_WIDTH-1:0] i_writedata;
  logic                  i_ex_memread;
  logic                  i_ex_regwrite;
  logic [4:0]            i_ex_rdest;
  logic                  i_mem_memread;
  logic                  i_mem_regwrite;
  logic [4:0]            i_mem_rdest;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  o_stall;
  logic                  o_flush;
  logic [DATA_WIDTH-1:0] o_pcbranch;
  logic                  o_idex_valid;
  logic [CTRL_W-1:0]     o_idex_ctrl;
  logic [DATA_WIDTH-1:0] o_idex_regA;
  logic [DATA_WIDTH-1:0] o_idex_regB;
  logic [DATA_WIDTH-1:0] o_idex_ext;
  logic [4:0]            o_idex_rs;
  logic [4:0]            o_idex_rt;
  logic [4:0]            o_idex_rd;

  modport master (
    output i_valid, i_instruccion, i_currentpc, i_ctrl, i_isbranch, i_beq_or_bne,
           i_zeroext, i_regwrite, i_rt_rd, i_writedata, i_ex_memread, i_ex_regwrite,
           i_ex_rdest, i_mem_memread, i_mem_regwrite, i_mem_rdest, i_mem_data,
    input  o_stall, o_flush, o_pcbranch, o_idex_valid, o_idex_ctrl, o_idex_regA,
           o_idex_regB, o_idex_ext, o_idex_rs, o_idex_rt, o_idex_rd
  );

  modport slave (
    input  i_valid, i_instruccion, i_currentpc, i_ctrl, i_isbranch, i_beq_or_bne,
           i_zeroext, i_regwrite, i_rt_rd, i_writedata, i_ex_memread, i_ex_regwrite,
           i_ex_rdest, i_mem_memread, i_mem_regwrite, i_mem_rdest, i_mem_data,
    output o_stall, o_flush, o_pcbranch, o_idex_valid, o_idex_ctrl, o_idex_regA,
           o_idex_regB, o_idex_ext, o_idex_rs, o_idex_rt, o_idex_rd
  );
endinterface

// File: rtl/decode_stage_hzd.sv
// MIPS decode stage: register file with optional write-through bypass,
// immediate extender, branch resolution in ID with MEM forwarding,
// load-use / branch-operand hazard detection and the ID/EX register.
module decode_stage_hzd #(
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 32,
  parameter int CTRL_W     = 9,
  parameter int BYPASS     = 1
) (
  input logic               i_clock,
  input logic               i_reset,
  decode_stage_hzd_if.slave bus
);
  localparam int IDX_W = $clog2(NREG);
  localparam int EXT_W = DATA_WIDTH - 16;

  logic [4:0]            rs, rt, rd;
  logic [15:0]           imm;
  logic [IDX_W-1:0]      rs_idx, rt_idx, wr_idx;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] regs [NREG];
  logic [DATA_WIDTH-1:0] rf_a, rf_b, br_a, br_b;
  logic [DATA_WIDTH-1:0] sext, ext;
  logic                  ex_hit, mem_hit, load_use, br_hazard, stall;
  logic                  mem_fwd_ok, br_equal;
  logic                  unused_opcode;

  assign rs     = bus.i_instruccion[25:21];
  assign rt     = bus.i_instruccion[20:16];
  assign rd     = bus.i_instruccion[15:11];
  assign imm    = bus.i_instruccion[15:0];
  assign unused_opcode = ^bus.i_instruccion[31:26];

  // Register index is the low bits of the 5-bit field, so small files alias.
  assign rs_idx = rs[IDX_W-1:0];
  assign rt_idx = rt[IDX_W-1:0];
  assign wr_idx = bus.i_rt_rd[IDX_W-1:0];
  // Entry 0 is never written, so it stays zero even when a field aliases onto it.
  assign wr_en  = bus.i_regwrite && (wr_idx != '0);

  // Register file storage; cleared asynchronously, written from WB.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_idx] <= bus.i_writedata;
    end
  end

  // Combinational reads, with same-cycle WB data returned when bypass is enabled.
  always_comb begin
    rf_a = regs[rs_idx];
    rf_b = regs[rt_idx];
    if (rs_idx == '0) rf_a = '0;
    else if (BYPASS != 0 && wr_en && wr_idx == rs_idx) rf_a = bus.i_writedata;
    if (rt_idx == '0) rf_b = '0;
    else if (BYPASS != 0 && wr_en && wr_idx == rt_idx) rf_b = bus.i_writedata;
  end

  // Immediate extension; the branch offset always uses the signed form.
  always_comb begin
    sext = {{EXT_W{imm[15]}}, imm};
    ext  = bus.i_zeroext ? {{EXT_W{1'b0}}, imm} : sext;
  end

  assign bus.o_pcbranch = bus.i_currentpc + {sext[DATA_WIDTH-3:0], 2'b00};

  // Hazard detection: dependence on an EX load, or a branch needing a result
  // that is not yet available for ID-stage forwarding.
  always_comb begin
    ex_hit    = (bus.i_ex_rdest != 5'd0) && (bus.i_ex_rdest == rs || bus.i_ex_rdest == rt);
    mem_hit   = (bus.i_mem_rdest != 5'd0) && (bus.i_mem_rdest == rs || bus.i_mem_rdest == rt);
    load_use  = bus.i_valid && bus.i_ex_memread && ex_hit;
    br_hazard = bus.i_valid && bus.i_isbranch &&
                ((bus.i_ex_regwrite && ex_hit) || (bus.i_mem_memread && mem_hit));
    stall     = load_use || br_hazard;
  end

  // Branch operands: a MEM-stage ALU result wins over the register file / WB bypass.
  always_comb begin
    mem_fwd_ok = bus.i_mem_regwrite && !bus.i_mem_memread && (bus.i_mem_rdest != 5'd0);
    br_a       = (mem_fwd_ok && bus.i_mem_rdest == rs) ? bus.i_mem_data : rf_a;
    br_b       = (mem_fwd_ok && bus.i_mem_rdest == rt) ? bus.i_mem_data : rf_b;
    br_equal   = (br_a == br_b);
  end

  assign bus.o_stall = stall;
  assign bus.o_flush = bus.i_valid && bus.i_isbranch && !stall &&
                       (bus.i_beq_or_bne ? br_equal : !br_equal);

  // ID/EX register: bubble on stall or empty slot, otherwise capture decode results.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset || stall || !bus.i_valid) begin
      bus.o_idex_valid <= 1'b0;
      bus.o_idex_ctrl  <= '0;
      bus.o_idex_regA  <= '0;
      bus.o_idex_regB  <= '0;
      bus.o_idex_ext   <= '0;
      bus.o_idex_rs    <= '0;
      bus.o_idex_rt    <= '0;
      bus.o_idex_rd    <= '0;
    end else begin
      bus.o_idex_valid <= 1'b1;
      bus.o_idex_ctrl  <= bus.i_ctrl;
      bus.o_idex_regA  <= rf_a;
      bus.o_idex_regB  <= rf_b;
      bus.o_idex_ext   <= ext;
      bus.o_idex_rs    <= rs;
      bus.o_idex_rt    <= rt;
      bus.o_idex_rd    <= rd;
    end
  end
endmodule

// File: doc/decode_stage_hzd.md
Name: decode_stage_hzd

Overview:
Parametrised second-generation instruction-decode stage for the 5-stage MIPS pipeline. It contains the register file with write-through bypass, the immediate extender, branch-target and branch resolution in ID with operand forwarding, load-use and branch-operand hazard detection with bubble insertion, and the ID/EX pipeline register. It sits between the IF/ID register and the execute stage. The control word comes from the external control decoder.

Parameters:
DATA_WIDTH, 32, datapath and register width
NREG, 32, register count (8, 16 or 32); index = low $clog2(NREG) bits of 5-bit field
CTRL_W, 9, width of control word carried to EX
BYPASS, 1, 1 = same-cycle WB write visible on read ports; 0 = old value read

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_valid  in  1  IF/ID holds a real instruction
i_instruccion  in  32  instruction from IF/ID
i_currentpc  in  DATA_WIDTH  PC+4 of this instruction
i_ctrl  in  CTRL_W  control word from decoder
i_isbranch  in  1  instruction is beq/bne
i_beq_or_bne  in  1  1 = beq, 0 = bne
i_zeroext  in  1  zero-extend immediate (andi/ori/xori)
i_regwrite  in  1  WB write enable
i_rt_rd  in  5  WB destination
i_writedata  in  DATA_WIDTH  WB data
i_ex_memread  in  1  EX-stage instruction is a load
i_ex_regwrite  in  1  EX-stage instruction writes a register
i_ex_rdest  in  5  EX-stage destination
i_mem_memread  in  1  MEM-stage instruction is a load
i_mem_regwrite  in  1  MEM-stage instruction writes a register
i_mem_rdest  in  5  MEM-stage destination
i_mem_data  in  DATA_WIDTH  MEM-stage ALU result
o_stall  out  1  freeze PC and IF/ID this cycle
o_flush  out  1  branch taken: clear IF/ID, load o_pcbranch
o_pcbranch  out  DATA_WIDTH  branch target
o_idex_valid  out  1  ID/EX holds a real instruction
o_idex_ctrl  out  CTRL_W  registered control word
o_idex_regA  out  DATA_WIDTH  registered rs value
o_idex_regB  out  DATA_WIDTH  registered rt value
o_idex_ext  out  DATA_WIDTH  registered extended immediate
o_idex_rs, o_idex_rt, o_idex_rd  out  5 each  registered fields [25:21],[20:16],[15:11]

Behaviour:
- Reset (async): all NREG registers = 0; all o_idex_* = 0. o_stall, o_flush and o_pcbranch are combinational and follow their inputs.
- Register file: write at posedge when i_regwrite and i_rt_rd != 0. Register 0 always reads 0. Reads are combinational. With BYPASS=1, a read of the register being written returns i_writedata.
- Extender: ext = {16{imm[15]}, imm} when i_zeroext=0, {16'b0, imm} when i_zeroext=1.
- o_pcbranch = i_currentpc + (sign-extended imm << 2), mod 2^DATA_WIDTH. Always sign-extended, independent of i_zeroext.
- Load-use hazard: i_valid & i_ex_memread & i_ex_rdest != 0 & (i_ex_rdest == rs or == rt).
- Branch hazard: i_valid & i_isbranch & any of the following, for dest != 0 matching rs or rt:
  - i_ex_regwrite with i_ex_rdest matching;
  - i_mem_memread with i_mem_rdest matching.
- o_stall = load-use hazard | branch hazard.
- Consequence: load followed by a dependent branch stalls 2 cycles; ALU op followed by a dependent branch stalls 1 cycle.
- Branch operand forwarding: when i_mem_regwrite & !i_mem_memread & i_mem_rdest == rs (rt), != 0, use i_mem_data. Otherwise use the register-file read. MEM forwarding has priority over WB bypass.
- o_flush = i_valid & i_isbranch & !o_stall & (i_beq_or_bne ? A == B : A != B), using forwarded operands.
- ID/EX update at each posedge:
  - if o_stall or !i_valid: load a bubble (valid = 0, ctrl = 0, data and fields = 0);
  - otherwise capture all fields with valid = 1.
  - The branch instruction itself proceeds into ID/EX normally.
- ID/EX carries the non-forwarded regfile values; EX-side forwarding is external.
- Latency: decode to ID/EX is 1 cycle; stall and flush decisions are same-cycle combinational.
- Reset asserted mid-stall clears the bubble state immediately. The stall/flush outputs then follow the inputs.

Test Plan:
1. Reset; write r5=0x1234 via WB; next cycle decode add r1,r5,r0 → o_idex_regA=0x1234 and o_idex_valid=1 after 1 clock. Same-cycle write+read of r5=0xBEEF with BYPASS=1 → regA=0xBEEF; with BYPASS=0 → regA=0x1234.
2. EX = lw to r2 (i_ex_memread=1, i_ex_rdest=2); ID = add r3,r2,r4 → o_stall=1 and bubble in ID/EX (valid=0, ctrl=0). Next cycle with EX cleared → instruction captured.
3. beq r1,r2 with MEM forwarding r1=7 (i_mem_data=7), r2 regfile=7 → o_flush=1. o_pcbranch = 0x100 + 4·0x0010 = 0x140 for currentpc=0x100, imm=0x0010.
4. bne, imm=0xFFFF, currentpc=0x200, operands 3 and 4 → o_flush=1, o_pcbranch=0x1FC. ori with imm=0x8000 → ext=0x00008000; addi with the same imm → ext=0xFFFF8000.
5. Sequence lw r2 → beq r2,r0 → o_stall=1 for exactly 2 cycles (EX load, then MEM load). Third cycle branch resolves with i_mem_data unused, regfile/bypass value used.
6. Async reset asserted mid-stall between clock edges → all o_idex_* = 0 immediately. Write to r0 → r0 still reads 0. NREG=8: field 9 aliases register 1.
